// File: rtl/piano_pkg.sv
// piano_pkg: shared constants and types for the piano voice allocator.
//   NUM_KEYS_DEF  default key count (C..B)
//   OCTAVE_MIN/MAX legal octave range; out-of-range octaves are clamped
//   key_idx_t     4-bit key index
//   base_period() octave-1 divider period per key, in clk cycles
package piano_pkg;

    localparam int unsigned NUM_KEYS_DEF = 12;
    localparam int unsigned KEY_W        = 4;
    localparam int unsigned OCT_W        = 4;
    localparam int unsigned AGE_W        = 4;

    typedef logic [KEY_W-1:0] key_idx_t;
    typedef logic [OCT_W-1:0] octave_t;

    localparam octave_t OCTAVE_MIN = 4'd1;
    localparam octave_t OCTAVE_MAX = 4'd7;

    // Action chosen for the key visited by the scanner this cycle.
    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_FREE,
        ACT_CLEAR,
        ACT_ALLOC,
        ACT_STEAL,
        ACT_WAIT
    } scan_act_e;

    function automatic logic [31:0] base_period(input key_idx_t k);
        case (k)
            4'd0:    return 32'd3057823;
            4'd1:    return 32'd2886169;
            4'd2:    return 32'd2724202;
            4'd3:    return 32'd2571289;
            4'd4:    return 32'd2427008;
            4'd5:    return 32'd2290741;
            4'd6:    return 32'd2162209;
            4'd7:    return 32'd2040858;
            4'd8:    return 32'd1926230;
            4'd9:    return 32'd1818182;
            4'd10:   return 32'd1716002;
            4'd11:   return 32'd1619827;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/voice_allocator_if.sv
// voice_allocator_if: key/octave inputs and voice outputs of the allocator.
//   master: switch/octave side (drives key_req, octave; observes voices)
//   slave : allocator side (reads key_req, octave; drives voice outputs)
interface voice_allocator_if #(
    parameter int unsigned NUM_KEYS   = piano_pkg::NUM_KEYS_DEF,
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned PERIOD_W   = 32
);

    logic [NUM_KEYS-1:0]                       key_req;
    piano_pkg::octave_t                        octave;
    logic [NUM_VOICES-1:0]                     voice_en;
    logic [NUM_VOICES*piano_pkg::KEY_W-1:0]    voice_key;
    logic [NUM_VOICES*PERIOD_W-1:0]            voice_period;
    logic [NUM_KEYS-1:0]                       key_sounding;
    logic                                      all_busy;

    modport master (
        output key_req, octave,
        input  voice_en, voice_key, voice_period, key_sounding, all_busy
    );

    modport slave (
        input  key_req, octave,
        output voice_en, voice_key, voice_period, key_sounding, all_busy
    );

endinterface

// File: rtl/voice_allocator_period_scaler.sv
// period_scaler: divider period for one voice.
//   key    : key index owned by the voice
//   octave : current octave, clamped to OCTAVE_MIN..OCTAVE_MAX
//   period : base_period(key) >> (octave-1), truncated to PERIOD_W
module period_scaler
    import piano_pkg::*;
#(
    parameter int unsigned PERIOD_W = 32
) (
    input  key_idx_t              key,
    input  octave_t               octave,
    output logic [PERIOD_W-1:0]   period
);

    octave_t     oct_c;
    octave_t     shamt;
    logic [31:0] shifted;

    always_comb begin
        if (octave < OCTAVE_MIN) begin
            oct_c = OCTAVE_MIN;
        end else if (octave > OCTAVE_MAX) begin
            oct_c = OCTAVE_MAX;
        end else begin
            oct_c = octave;
        end
        shamt   = oct_c - OCTAVE_MIN;
        shifted = base_period(key) >> shamt;
        period  = PERIOD_W'(shifted);
    end

endmodule

// File: rtl/voice_allocator.sv
// voice_allocator: shares NUM_VOICES tone-generator voices among NUM_KEYS keys.
//   clk, rst_n : system clock, asynchronous active-low reset
//   bus (slave): key_req/octave in; voice_en, voice_key, voice_period,
//                key_sounding, all_busy out
// A free-running scanner visits one key per cycle, frees the voice of a
// released key and gives a pressed key the lowest-index free voice.
// Optional macro VOICE_STEAL_EN: when no voice is free, the oldest voice is
// stolen and its previous owner is locked out until released.
module voice_allocator
    import piano_pkg::*;
#(
    parameter int unsigned NUM_KEYS   = NUM_KEYS_DEF,
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned PERIOD_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    voice_allocator_if.slave bus
);

    localparam int unsigned VIDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    typedef logic [VIDX_W-1:0] vidx_t;

    key_idx_t              scan_q, scan_d;
    logic [NUM_VOICES-1:0] voice_en_q, voice_en_d;
    key_idx_t              voice_key_q [NUM_VOICES];
    key_idx_t              voice_key_d [NUM_VOICES];
    logic [PERIOD_W-1:0]   period_q [NUM_VOICES];
    logic [PERIOD_W-1:0]   period_d [NUM_VOICES];
    logic [PERIOD_W-1:0]   scaled   [NUM_VOICES];

    scan_act_e act;
    logic      owns;
    vidx_t     owner;
    logic      free_any;
    vidx_t     free_idx;
    logic      stolen_cur;

`ifdef VOICE_STEAL_EN
    logic [NUM_KEYS-1:0] stolen_q, stolen_d;
    logic [AGE_W-1:0]    age_q [NUM_VOICES];
    logic [AGE_W-1:0]    age_d [NUM_VOICES];
    vidx_t               oldest;
    vidx_t               tgt;
    logic [AGE_W-1:0]    best_age;

    assign stolen_cur = stolen_q[scan_q];
`else
    assign stolen_cur = 1'b0;
`endif

    // Ownership lookup and per-key action for the scanned key.
    always_comb begin
        scan_d      = (scan_q == key_idx_t'(NUM_KEYS - 1)) ? '0 : scan_q + 1'b1;
        voice_en_d  = voice_en_q;
        voice_key_d = voice_key_q;
        owns        = 1'b0;
        owner       = '0;
        free_any    = 1'b0;
        free_idx    = '0;
        act         = ACT_NONE;

        for (int unsigned v = 0; v < NUM_VOICES; v++) begin
            if (voice_en_q[v] && (voice_key_q[v] == scan_q)) begin
                owns  = 1'b1;
                owner = vidx_t'(v);
            end
            if (!voice_en_q[v] && !free_any) begin
                free_any = 1'b1;
                free_idx = vidx_t'(v);
            end
        end

        if (!bus.key_req[scan_q]) begin
            act = owns ? ACT_FREE : ACT_CLEAR;
        end else if (!owns && !stolen_cur) begin
`ifdef VOICE_STEAL_EN
            act = free_any ? ACT_ALLOC : ACT_STEAL;
`else
            act = free_any ? ACT_ALLOC : ACT_WAIT;
`endif
        end

        case (act)
            ACT_FREE:  voice_en_d[owner] = 1'b0;
            ACT_ALLOC: begin
                voice_en_d[free_idx]  = 1'b1;
                voice_key_d[free_idx] = scan_q;
            end
`ifdef VOICE_STEAL_EN
            ACT_STEAL: voice_key_d[oldest] = scan_q;
`endif
            default: ;
        endcase
    end

`ifdef VOICE_STEAL_EN
    // Oldest voice (largest age, lowest index on ties); ages and stolen flags.
    always_comb begin
        oldest   = '0;
        best_age = age_q[0];
        for (int unsigned v = 1; v < NUM_VOICES; v++) begin
            if (age_q[v] > best_age) begin
                best_age = age_q[v];
                oldest   = vidx_t'(v);
            end
        end

        stolen_d = stolen_q;
        age_d    = age_q;
        tgt      = (act == ACT_ALLOC) ? free_idx : oldest;

        case (act)
            ACT_FREE, ACT_CLEAR: stolen_d[scan_q] = 1'b0;
            ACT_STEAL:           stolen_d[voice_key_q[oldest]] = 1'b1;
            default: ;
        endcase

        if ((act == ACT_ALLOC) || (act == ACT_STEAL)) begin
            for (int unsigned v = 0; v < NUM_VOICES; v++) begin
                if (vidx_t'(v) == tgt) begin
                    age_d[v] = '0;
                end else if (voice_en_q[v] && (age_q[v] != '1)) begin
                    age_d[v] = age_q[v] + 1'b1;
                end
            end
        end
    end
`endif

    for (genvar gv = 0; gv < NUM_VOICES; gv++) begin : g_scaler
        period_scaler #(.PERIOD_W(PERIOD_W)) u_scaler (
            .key    (voice_key_q[gv]),
            .octave (bus.octave),
            .period (scaled[gv])
        );
    end

    always_comb begin
        for (int unsigned v = 0; v < NUM_VOICES; v++) begin
            period_d[v] = voice_en_q[v] ? scaled[v] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_q     <= '0;
            voice_en_q <= '0;
            for (int unsigned v = 0; v < NUM_VOICES; v++) begin
                voice_key_q[v] <= '0;
                period_q[v]    <= '0;
            end
        end else begin
            scan_q      <= scan_d;
            voice_en_q  <= voice_en_d;
            voice_key_q <= voice_key_d;
            period_q    <= period_d;
        end
    end

`ifdef VOICE_STEAL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stolen_q <= '0;
            for (int unsigned v = 0; v < NUM_VOICES; v++) begin
                age_q[v] <= '0;
            end
        end else begin
            stolen_q <= stolen_d;
            age_q    <= age_d;
        end
    end
`endif

    // Outputs derive from registered ownership, so they move on the action edge.
    always_comb begin
        bus.voice_key    = '0;
        bus.voice_period = '0;
        bus.key_sounding = '0;
        for (int unsigned v = 0; v < NUM_VOICES; v++) begin
            bus.voice_key[v*KEY_W +: KEY_W]          = voice_key_q[v];
            bus.voice_period[v*PERIOD_W +: PERIOD_W] = period_q[v];
        end
        for (int unsigned k = 0; k < NUM_KEYS; k++) begin
            for (int unsigned v = 0; v < NUM_VOICES; v++) begin
                if (voice_en_q[v] && (voice_key_q[v] == key_idx_t'(k))) begin
                    bus.key_sounding[k] = 1'b1;
                end
            end
        end
    end

    assign bus.voice_en = voice_en_q;
    assign bus.all_busy = &voice_en_q;

endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: scoreboard bench for voice_allocator.
// Expected allocation events {voice, key} are queued as stimulus is applied;
// a monitor records observed allocations (voice enabled or re-keyed) and the
// scenario tasks pop and compare both queues.
module tb_voice_allocator;

    localparam int unsigned NK = 12;
    localparam int unsigned NV = 4;
    localparam int unsigned PW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    voice_allocator_if #(.NUM_KEYS(NK), .NUM_VOICES(NV), .PERIOD_W(PW)) bus ();

    voice_allocator #(.NUM_KEYS(NK), .NUM_VOICES(NV), .PERIOD_W(PW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    logic [7:0] exp_q [$];
    logic [7:0] obs_q [$];

    logic [NV-1:0]   prev_en  = '0;
    logic [NV*4-1:0] prev_key = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            for (int v = 0; v < NV; v++) begin
                if (bus.voice_en[v] &&
                    (!prev_en[v] || (bus.voice_key[v*4 +: 4] != prev_key[v*4 +: 4]))) begin
                    obs_q.push_back({4'(v), bus.voice_key[v*4 +: 4]});
                end
            end
        end
        prev_en  = bus.voice_en;
        prev_key = bus.voice_key;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] exp_period(input int key, input int oct);
        logic [31:0] t [12];
        int          o;
        t = '{32'd3057823, 32'd2886169, 32'd2724202, 32'd2571289, 32'd2427008, 32'd2290741,
              32'd2162209, 32'd2040858, 32'd1926230, 32'd1818182, 32'd1716002, 32'd1619827};
        o = (oct < 1) ? 1 : ((oct > 7) ? 7 : oct);
        return t[key] >> (o - 1);
    endfunction

    // Sample/drive point: just after the falling edge, clear of the monitor.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_events(input int unsigned n, input int unsigned bound);
        int unsigned cyc = 0;
        while ((obs_q.size() < n) && (cyc < bound)) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        bus.key_req = '0;
        bus.octave  = 4'd1;
        rst_n = 1'b0;
        tick();
        n_tests++; if (bus.voice_en !== 4'h0) begin n_fail++; $display("FAIL reset_en: got %h want 0", bus.voice_en); end
        n_tests++; if (bus.voice_key !== 16'h0) begin n_fail++; $display("FAIL reset_key: got %h want 0", bus.voice_key); end
        n_tests++; if (bus.voice_period !== '0) begin n_fail++; $display("FAIL reset_period: got %h want 0", bus.voice_period); end
        n_tests++; if (bus.key_sounding !== 12'h0) begin n_fail++; $display("FAIL reset_sounding: got %h want 0", bus.key_sounding); end
        n_tests++; if (bus.all_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.all_busy); end
    endtask

    task automatic test_single_key();
        logic [7:0] e, o;
        obs_q.delete();
        exp_q.push_back({4'd0, 4'd0});
        bus.key_req = 12'h001;
        rst_n = 1'b1;
        wait_events(1, 13);
        e = exp_q.pop_front();
        n_tests++;
        if (obs_q.size() == 0) begin
            n_fail++; $display("FAIL single_alloc: no allocation within 13 cycles, want %h", e);
        end else begin
            o = obs_q.pop_front();
            if (o !== e) begin n_fail++; $display("FAIL single_alloc: got %h want %h", o, e); end
        end
        n_tests++; if (bus.voice_en !== 4'b0001) begin n_fail++; $display("FAIL single_en: got %b want 0001", bus.voice_en); end
        n_tests++; if (bus.key_sounding !== 12'h001) begin n_fail++; $display("FAIL single_sounding: got %h want 001", bus.key_sounding); end
        tick();
        n_tests++;
        if (bus.voice_period[31:0] !== exp_period(0, 1)) begin
            n_fail++; $display("FAIL single_period: got %0d want %0d", bus.voice_period[31:0], exp_period(0, 1));
        end
    endtask

    task automatic test_octave();
        int unsigned cyc;
        bus.octave = 4'd3;
        tick();
        n_tests++; if (bus.voice_period[31:0] !== 32'd764455) begin n_fail++; $display("FAIL oct3_period: got %0d want 764455", bus.voice_period[31:0]); end
        n_tests++; if (bus.voice_en !== 4'b0001) begin n_fail++; $display("FAIL oct3_en: got %b want 0001", bus.voice_en); end
        n_tests++; if (bus.voice_key[3:0] !== 4'd0) begin n_fail++; $display("FAIL oct3_key: got %0d want 0", bus.voice_key[3:0]); end
        bus.octave = 4'd0;
        tick();
        n_tests++; if (bus.voice_period[31:0] !== exp_period(0, 0)) begin n_fail++; $display("FAIL oct0_clamp: got %0d want %0d", bus.voice_period[31:0], exp_period(0, 0)); end
        bus.octave = 4'd9;
        tick();
        n_tests++; if (bus.voice_period[31:0] !== exp_period(0, 9)) begin n_fail++; $display("FAIL oct9_clamp: got %0d want %0d", bus.voice_period[31:0], exp_period(0, 9)); end
        bus.octave  = 4'd1;
        bus.key_req = 12'h000;
        cyc = 0;
        while ((bus.voice_en !== 4'h0) && (cyc < 13)) begin tick(); cyc++; end
        n_tests++; if (bus.voice_en !== 4'h0) begin n_fail++; $display("FAIL release_en: got %b want 0000", bus.voice_en); end
        n_tests++; if (bus.key_sounding !== 12'h0) begin n_fail++; $display("FAIL release_sounding: got %h want 0", bus.key_sounding); end
        tick();
        n_tests++; if (bus.voice_period[31:0] !== 32'd0) begin n_fail++; $display("FAIL release_period: got %0d want 0", bus.voice_period[31:0]); end
    endtask

    task automatic test_five_keys();
        logic [7:0] e, o;
        rst_n = 1'b0;
        tick();
        obs_q.delete();
        exp_q.delete();
        exp_q.push_back({4'd0, 4'd0});
        exp_q.push_back({4'd1, 4'd2});
        exp_q.push_back({4'd2, 4'd4});
        exp_q.push_back({4'd3, 4'd7});
        bus.key_req = 12'h295;
        rst_n = 1'b1;
        wait_events(4, 2 * NK);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (obs_q.size() == 0) begin
                n_fail++; $display("FAIL five_alloc: missing allocation, want %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL five_alloc: got %h want %h", o, e); end
            end
        end
        n_tests++; if (bus.all_busy !== 1'b1) begin n_fail++; $display("FAIL five_busy: got %b want 1", bus.all_busy); end
        n_tests++; if (bus.key_sounding !== 12'h095) begin n_fail++; $display("FAIL five_sounding: got %h want 095", bus.key_sounding); end
        n_tests++; if (bus.voice_key !== 16'h7420) begin n_fail++; $display("FAIL five_keys: got %h want 7420", bus.voice_key); end
    endtask

`ifndef VOICE_STEAL_EN
    task automatic test_release_refill();
        logic [7:0] e, o;
        obs_q.delete();
        repeat (NK) tick();
        n_tests++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL wait_noalloc: got %0d events want 0", obs_q.size()); end
        n_tests++; if (bus.key_sounding[9] !== 1'b0) begin n_fail++; $display("FAIL wait_key9: got %b want 0", bus.key_sounding[9]); end
        obs_q.delete();
        exp_q.push_back({4'd1, 4'd9});
        bus.key_req = 12'h291;
        wait_events(1, 2 * NK);
        e = exp_q.pop_front();
        n_tests++;
        if (obs_q.size() == 0) begin
            n_fail++; $display("FAIL refill_alloc: no allocation, want %h", e);
        end else begin
            o = obs_q.pop_front();
            if (o !== e) begin n_fail++; $display("FAIL refill_alloc: got %h want %h", o, e); end
        end
        n_tests++; if (bus.key_sounding !== 12'h291) begin n_fail++; $display("FAIL refill_sounding: got %h want 291", bus.key_sounding); end
        n_tests++; if (bus.all_busy !== 1'b1) begin n_fail++; $display("FAIL refill_busy: got %b want 1", bus.all_busy); end
    endtask
`else
    task automatic test_steal();
        logic [7:0] e, o;
        obs_q.delete();
        exp_q.push_back({4'd0, 4'd9});
        wait_events(1, NK);
        e = exp_q.pop_front();
        n_tests++;
        if (obs_q.size() == 0) begin
            n_fail++; $display("FAIL steal_alloc: no steal, want %h", e);
        end else begin
            o = obs_q.pop_front();
            if (o !== e) begin n_fail++; $display("FAIL steal_alloc: got %h want %h", o, e); end
        end
        repeat (NK) tick();
        n_tests++; if (bus.key_sounding !== 12'h294) begin n_fail++; $display("FAIL steal_sounding: got %h want 294", bus.key_sounding); end
        n_tests++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL steal_locked: got %0d events want 0", obs_q.size()); end
        bus.key_req = 12'h294;
        repeat (NK) tick();
        bus.key_req = 12'h290;
        repeat (NK) tick();
        n_tests++; if (bus.voice_en !== 4'b1101) begin n_fail++; $display("FAIL steal_free: got %b want 1101", bus.voice_en); end
        obs_q.delete();
        exp_q.push_back({4'd1, 4'd0});
        bus.key_req = 12'h291;
        wait_events(1, 2 * NK);
        e = exp_q.pop_front();
        n_tests++;
        if (obs_q.size() == 0) begin
            n_fail++; $display("FAIL repress_alloc: no allocation, want %h", e);
        end else begin
            o = obs_q.pop_front();
            if (o !== e) begin n_fail++; $display("FAIL repress_alloc: got %h want %h", o, e); end
        end
        n_tests++; if (bus.key_sounding !== 12'h291) begin n_fail++; $display("FAIL repress_sounding: got %h want 291", bus.key_sounding); end
    endtask
`endif

    task automatic test_async_reset();
        logic [7:0] e, o;
        n_tests++; if (bus.all_busy !== 1'b1) begin n_fail++; $display("FAIL arst_pre_busy: got %b want 1", bus.all_busy); end
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        n_tests++; if (bus.voice_en !== 4'h0) begin n_fail++; $display("FAIL arst_en: got %b want 0000", bus.voice_en); end
        n_tests++; if (bus.key_sounding !== 12'h0) begin n_fail++; $display("FAIL arst_sounding: got %h want 0", bus.key_sounding); end
        n_tests++; if (bus.all_busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy: got %b want 0", bus.all_busy); end
        tick();
        obs_q.delete();
        exp_q.delete();
        exp_q.push_back({4'd0, 4'd0});
        exp_q.push_back({4'd1, 4'd4});
        exp_q.push_back({4'd2, 4'd7});
        exp_q.push_back({4'd3, 4'd9});
        rst_n = 1'b1;
        wait_events(4, 2 * NK);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (obs_q.size() == 0) begin
                n_fail++; $display("FAIL arst_realloc: missing allocation, want %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL arst_realloc: got %h want %h", o, e); end
            end
        end
        n_tests++; if (bus.key_sounding !== 12'h291) begin n_fail++; $display("FAIL arst_sounding2: got %h want 291", bus.key_sounding); end
    endtask

    initial begin
        test_reset();
        test_single_key();
        test_octave();
        test_five_keys();
`ifndef VOICE_STEAL_EN
        test_release_refill();
`else
        test_steal();
`endif
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
